ahmes_fetch: RTL

Instruction fetch unit for the Ahmes CPU, sitting directly downstream of the program counter. It reads opcode and operand bytes from memory at the current PC, tells the PC when to increment, and holds one complete instruction (opcode plus optional address byte) for the decode/execute stage under a valid/ready handshake. Taken jumps are handled by execute, which loads the PC and flushes this block.

---
 rtl/ahmes_pkg.sv | 42 ++++
 rtl/ahmes_fetch.sv | 105 ++++++++++
 2 files changed

// File: rtl/ahmes_pkg.sv
// ============================================================================
// Module : ahmes_pkg
// Brief  : Shared Ahmes CPU opcodes, fetch state encoding and length decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ahmes_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_STA = 8'h10;
  localparam logic [7:0] OP_LDA = 8'h20;
  localparam logic [7:0] OP_ADD = 8'h30;
  localparam logic [7:0] OP_OR  = 8'h40;
  localparam logic [7:0] OP_AND = 8'h50;
  localparam logic [7:0] OP_NOT = 8'h60;
  localparam logic [7:0] OP_SUB = 8'h70;
  localparam logic [7:0] OP_JMP = 8'h80;
  localparam logic [7:0] OP_HLT = 8'hF0;

  typedef enum logic [1:0] {
    FETCH_OP    = 2'd0,
    FETCH_ARG   = 2'd1,
    FETCH_ISSUE = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_t;

  // Length depends only on the high nibble; the NOT group (0x6x) is one byte.
  function automatic logic ahmes_is_two_byte(input logic [7:0] opcode);
    logic r;
    r = 1'b0;
    case (opcode[7:4])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahmes_fetch.sv
// ============================================================================
// Module : ahmes_fetch
// Brief  : Ahmes instruction fetch; reads opcode/operand at PC and holds one
//          instruction for execute. Optional AHMES_FETCH_STATS_EN adds
//          instr_count (accepted-instruction counter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahmes_fetch
  import ahmes_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_len2,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush,
  output logic              halted
`ifdef AHMES_FETCH_STATS_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam logic [1:0] S_OP    = FETCH_OP;
  localparam logic [1:0] S_ARG   = FETCH_ARG;
  localparam logic [1:0] S_ISSUE = FETCH_ISSUE;
  localparam logic [1:0] S_HALT  = FETCH_HALT;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_run;
  logic       w_take;
  logic       w_is_hlt;

  // r_run keeps mem_req low during reset and for the reset-release cycle.
  assign mem_req  = r_run & ((r_state == S_OP) | (r_state == S_ARG));
  assign w_take   = mem_req & mem_ack & ~flush;
  assign pc_inc   = w_take;
  assign mem_addr = pc_value;

  assign instr_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);
  assign w_is_hlt    = (instr_opcode[DATA_W-1 -: 4] == OP_HLT[7:4]);

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_OP;
    end else begin
      case (r_state)
        S_OP:    if (w_take) w_next = ahmes_is_two_byte(mem_rdata) ? S_ARG : S_ISSUE;
        S_ARG:   if (w_take) w_next = S_ISSUE;
        S_ISSUE: if (instr_ready) w_next = w_is_hlt ? S_HALT : S_OP;
        default: w_next = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_OP;
      r_run         <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_len2    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (w_take && r_state == S_OP) begin
        instr_opcode  <= mem_rdata;
        instr_operand <= '0;
        instr_len2    <= ahmes_is_two_byte(mem_rdata);
      end
      if (w_take && r_state == S_ARG) begin
        instr_operand <= mem_rdata;
      end
    end
  end

`ifdef AHMES_FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= 16'd0;
    end else if (instr_valid && instr_ready && !flush) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
